// File: rtl/barrel_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and
// the single-stage shift helper used by every pipeline stage.
package barrel_pkg;

    localparam logic [1:0] MODE_ROL = 2'b00;
    localparam logic [1:0] MODE_ROR = 2'b01;
    localparam logic [1:0] MODE_SLL = 2'b10;
    localparam logic [1:0] MODE_SRA = 2'b11;

    localparam int MAX_WIDTH = 256;

    // Shift the low 'width' bits of data by 'step' positions; width and step are
    // elaboration constants at every call site, so the loop folds into wiring.
    function automatic logic [MAX_WIDTH-1:0] stage_shift(
        input logic [MAX_WIDTH-1:0] data,
        input int                   width,
        input int                   step,
        input logic [1:0]           mode,
        input logic                 sign
    );
        logic [MAX_WIDTH-1:0] res;
        logic [7:0]           idx;
        res = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            idx = '0;
            if (i < width) begin
                case (mode)
                    MODE_ROL: begin
                        idx    = 8'((i - step + width) % width);
                        res[i] = data[idx];
                    end
                    MODE_ROR: begin
                        idx    = 8'((i + step) % width);
                        res[i] = data[idx];
                    end
                    MODE_SLL: begin
                        if (i >= step) begin
                            idx    = 8'(i - step);
                            res[i] = data[idx];
                        end
                    end
                    default: begin
                        if (i + step < width) begin
                            idx    = 8'(i + step);
                            res[i] = data[idx];
                        end else begin
                            res[i] = sign;
                        end
                    end
                endcase
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One registered pipeline stage: applies a fixed shift of STEP when its
// amount bit is set, with valid/ready flow control toward the next stage.
module barrel_shift_stage
    import barrel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     up_valid,
    output logic                     up_ready,
    input  logic [WIDTH-1:0]         up_data,
    input  logic [$clog2(WIDTH)-1:0] up_amt,
    input  logic [1:0]               up_mode,
    input  logic                     up_sign,
    output logic                     dn_valid,
    input  logic                     dn_ready,
    output logic [WIDTH-1:0]         dn_data,
    output logic [$clog2(WIDTH)-1:0] dn_amt,
    output logic [1:0]               dn_mode,
    output logic                     dn_sign
);

    localparam int BIT = $clog2(STEP);

    logic             advance;
    logic [WIDTH-1:0] shifted;

    // An empty stage always advances, which lets bubbles collapse toward the output.
    assign advance  = !dn_valid || dn_ready;
    assign up_ready = advance;

    always_comb begin
        shifted = up_data;
        if (up_amt[BIT]) begin
            shifted = WIDTH'(stage_shift(MAX_WIDTH'(up_data), WIDTH, STEP, up_mode, up_sign));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
            dn_amt   <= '0;
            dn_mode  <= '0;
            dn_sign  <= 1'b0;
        end else if (advance) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= shifted;
                dn_amt  <= up_amt;
                dn_mode <= up_mode;
                dn_sign <= up_sign;
            end
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter/rotator: one register stage per shift-amount bit,
// valid/ready streaming on both sides, one operation per clock when unstalled.
module barrel_shifter_pipe
    import barrel_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH),
    localparam int NSTG  = SHW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_mode,
    output logic             busy
);

    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("barrel_shifter_pipe: WIDTH must be a power of two between 4 and MAX_WIDTH");
    end

    logic [NSTG:0]            vld;
    logic [NSTG:0]            rdy;
    logic [NSTG:0]            sgn;
    logic [NSTG:0][WIDTH-1:0] dat;
    logic [NSTG:0][SHW-1:0]   amt;
    logic [NSTG:0][1:0]       mde;
    logic                     unused_tail;

    // The sign is captured from the untouched operand so every stage fills with it.
    assign vld[0]    = in_valid;
    assign dat[0]    = in_data;
    assign amt[0]    = in_amt;
    assign mde[0]    = in_mode;
    assign sgn[0]    = in_data[WIDTH-1];
    assign rdy[NSTG] = out_ready;

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        barrel_shift_stage #(
            .WIDTH(WIDTH),
            .STEP (1 << k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .up_valid(vld[k]),
            .up_ready(rdy[k]),
            .up_data (dat[k]),
            .up_amt  (amt[k]),
            .up_mode (mde[k]),
            .up_sign (sgn[k]),
            .dn_valid(vld[k+1]),
            .dn_ready(rdy[k+1]),
            .dn_data (dat[k+1]),
            .dn_amt  (amt[k+1]),
            .dn_mode (mde[k+1]),
            .dn_sign (sgn[k+1])
        );
    end

    assign in_ready    = rdy[0];
    assign out_valid   = vld[NSTG];
    assign out_data    = dat[NSTG];
    assign out_mode    = mde[NSTG];
    assign busy        = |vld[NSTG:1];
    assign unused_tail = ^{amt[NSTG], sgn[NSTG]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe: 8-bit vector table, stall and reset
// sequences, plus a 32-bit sweep of every mode and amount against a model.
module tb_barrel_shifter_pipe;

    localparam logic [1:0] ROL = 2'b00;
    localparam logic [1:0] ROR = 2'b01;
    localparam logic [1:0] SLL = 2'b10;
    localparam logic [1:0] SRA = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  in_data, out_data;
    logic [2:0]  in_amt;
    logic [1:0]  in_mode, out_mode;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [31:0] b_in_data, b_out_data;
    logic [4:0]  b_in_amt;
    logic [1:0]  b_in_mode, b_out_mode;

    int total_checks = 0;
    int bad_checks   = 0;

    typedef struct {
        logic [7:0] data;
        logic [2:0] amt;
        logic [1:0] mode;
        logic [7:0] exp;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    barrel_shifter_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mode(out_mode), .busy(busy)
    );

    barrel_shifter_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_amt(b_in_amt), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_mode(b_out_mode), .busy(b_busy)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m, input logic v);
        in_data  = d;
        in_amt   = a;
        in_mode  = m;
        in_valid = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model32(input logic [31:0] d, input int a, input logic [1:0] m);
        logic [63:0] t;
        case (m)
            ROL:     begin t = {d, d} << a; return t[63:32]; end
            ROR:     begin t = {d, d} >> a; return t[31:0]; end
            SLL:     return d << a;
            default: return 32'($signed(d) >>> a);
        endcase
    endfunction

    initial begin
        int lat;
        int acc;
        int got;
        int stale;
        logic [31:0] d32;

        vecs[0]  = '{8'hB4, 3'd1, ROR, 8'h5A};
        vecs[1]  = '{8'hB4, 3'd5, SLL, 8'h80};
        vecs[2]  = '{8'hB4, 3'd2, SRA, 8'hED};
        vecs[3]  = '{8'hB4, 3'd0, ROL, 8'hB4};
        vecs[4]  = '{8'h7F, 3'd7, SRA, 8'h00};
        vecs[5]  = '{8'h80, 3'd7, SRA, 8'hFF};
        vecs[6]  = '{8'h01, 3'd1, ROR, 8'h80};
        vecs[7]  = '{8'hB4, 3'd3, ROL, 8'hA5};
        vecs[8]  = '{8'h3C, 3'd0, SLL, 8'h3C};
        vecs[9]  = '{8'hC3, 3'd4, ROR, 8'h3C};
        vecs[10] = '{8'h81, 3'd1, SLL, 8'h02};
        vecs[11] = '{8'h96, 3'd0, SRA, 8'h96};
        vecs[12] = '{8'h96, 3'd7, ROL, 8'h4B};
        vecs[13] = '{8'h40, 3'd6, SRA, 8'h01};

        rst_n = 1'b0;
        apply_stimulus(8'h00, 3'd0, ROL, 1'b0);
        out_ready   = 1'b1;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_in_amt    = '0;
        b_in_mode   = '0;
        b_out_ready = 1'b1;

        #12;
        check_output("reset_out_valid", 32'(out_valid), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_out_data", 32'(out_data), 32'd0);
        check_output("reset_out_mode", 32'(out_mode), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_output("reset_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] single ROL op with latency measurement");
        apply_stimulus(8'hB4, 3'd3, ROL, 1'b1);
        tick();
        apply_stimulus(8'h00, 3'd0, ROL, 1'b0);
        check_output("single_busy", 32'(busy), 32'd1);
        check_output("single_early_valid", 32'(out_valid), 32'd0);
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check_output("single_latency", 32'(lat), 32'd3);
        check_output("single_data", 32'(out_data), 32'hA5);
        check_output("single_mode", 32'(out_mode), 32'(ROL));
        tick();
        check_output("single_drained_valid", 32'(out_valid), 32'd0);
        check_output("single_drained_busy", 32'(busy), 32'd0);

        $display("[TB] back-to-back vector table");
        for (int c = 0; c < NVEC + 2; c++) begin
            if (c < NVEC) apply_stimulus(vecs[c].data, vecs[c].amt, vecs[c].mode, 1'b1);
            else          apply_stimulus(8'h00, 3'd0, ROL, 1'b0);
            #1;
            if (c < NVEC) check_output($sformatf("vec%0d_in_ready", c), 32'(in_ready), 32'd1);
            tick();
            if (c >= 2) begin
                check_output($sformatf("vec%0d_valid", c - 2), 32'(out_valid), 32'd1);
                check_output($sformatf("vec%0d_data", c - 2), 32'(out_data), 32'(vecs[c-2].exp));
                check_output($sformatf("vec%0d_mode", c - 2), 32'(out_mode), 32'(vecs[c-2].mode));
            end
        end
        tick();
        check_output("table_drained_valid", 32'(out_valid), 32'd0);

        $display("[TB] back-pressure with five queued ops");
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            apply_stimulus(8'(acc + 1), 3'd1, ROL, acc < 5);
            #1;
            if (in_valid && in_ready) acc++;
            tick();
        end
        apply_stimulus(8'(acc + 1), 3'd1, ROL, 1'b1);
        #1;
        check_output("stall_accepted", 32'(acc), 32'd3);
        check_output("stall_in_ready", 32'(in_ready), 32'd0);
        check_output("stall_out_valid", 32'(out_valid), 32'd1);
        check_output("stall_out_data", 32'(out_data), 32'h02);
        tick();
        tick();
        check_output("stall_hold_data", 32'(out_data), 32'h02);
        check_output("stall_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 5; c++) begin
            apply_stimulus(8'(acc + 1), 3'd1, ROL, acc < 5);
            #1;
            if (in_valid && in_ready) acc++;
            if (out_valid) begin
                check_output($sformatf("release%0d_data", got), 32'(out_data), 32'(2 * (got + 1)));
                got++;
            end
            tick();
        end
        apply_stimulus(8'h00, 3'd0, ROL, 1'b0);
        check_output("release_count", 32'(got), 32'd5);
        check_output("release_accepted", 32'(acc), 32'd5);

        $display("[TB] reset with entries in flight");
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            apply_stimulus(8'hF0 + 8'(c), 3'd2, SLL, 1'b1);
            tick();
        end
        apply_stimulus(8'h00, 3'd0, ROL, 1'b0);
        check_output("flight_out_valid", 32'(out_valid), 32'd1);
        check_output("flight_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midreset_out_valid", 32'(out_valid), 32'd0);
        check_output("midreset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid) stale++;
        end
        check_output("midreset_stale", 32'(stale), 32'd0);
        check_output("midreset_out_data", 32'(out_data), 32'd0);

        $display("[TB] 32-bit sweep of all modes and amounts");
        for (int m = 0; m < 4; m++) begin
            for (int a = 0; a < 32; a++) begin
                d32 = $urandom;
                b_in_data  = d32;
                b_in_amt   = 5'(a);
                b_in_mode  = 2'(m);
                b_in_valid = 1'b1;
                tick();
                b_in_valid = 1'b0;
                lat = 1;
                while (!b_out_valid && lat < 12) begin
                    tick();
                    lat++;
                end
                check_output($sformatf("w32_m%0d_a%0d_lat", m, a), 32'(lat), 32'd5);
                check_output($sformatf("w32_m%0d_a%0d_data", m, a), b_out_data, model32(d32, a, 2'(m)));
                check_output($sformatf("w32_m%0d_a%0d_mode", m, a), 32'(b_out_mode), 32'(m));
            end
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
